// File: rtl/mem_arbiter.sv
// Two-port arbiter for a single-port synchronous RAM: fixed priority to port A,
// with a starvation guard that forces a port B grant after STARVE_LIMIT contested losses.
module mem_arbiter #(
    parameter int unsigned AW           = 8,
    parameter int unsigned DW           = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC_A = 3'd1,
        ACC_B = 3'd2,
        RSP_A = 3'd3,
        RSP_B = 3'd4
    } state_t;

    state_t        state_q;
    logic [CW-1:0] starve_q;
    logic [AW-1:0] mem_addr_q;
    logic          mem_we_q;
    logic [DW-1:0] mem_din_q;
    logic          rd_q;
    logic          a_ack_q;
    logic          b_ack_q;
    logic [DW-1:0] a_rdata_q;
    logic [DW-1:0] b_rdata_q;
    logic          busy_q;

    logic a_win_c;
    logic b_win_c;

    // A wins unless B is also asking and has already lost LIMIT times in a row
    assign a_win_c = a_req && (!b_req || (starve_q < LIMIT));
    assign b_win_c = b_req && !a_win_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            mem_din_q  <= '0;
            rd_q       <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (a_win_c) begin
                        state_q    <= ACC_A;
                        busy_q     <= 1'b1;
                        mem_addr_q <= a_addr;
                        mem_we_q   <= a_we;
                        mem_din_q  <= a_wdata;
                        rd_q       <= !a_we;
                        if (b_req && (starve_q < LIMIT)) begin
                            starve_q <= starve_q + CW'(1);
                        end
                    end else if (b_win_c) begin
                        state_q    <= ACC_B;
                        busy_q     <= 1'b1;
                        mem_addr_q <= b_addr;
                        mem_we_q   <= b_we;
                        mem_din_q  <= b_wdata;
                        rd_q       <= !b_we;
                        starve_q   <= '0;
                    end
                end
                ACC_A: begin
                    mem_we_q <= 1'b0;
                    a_ack_q  <= 1'b1;
                    state_q  <= RSP_A;
                end
                ACC_B: begin
                    mem_we_q <= 1'b0;
                    b_ack_q  <= 1'b1;
                    state_q  <= RSP_B;
                end
                RSP_A: begin
                    if (rd_q) begin
                        a_rdata_q <= mem_dout;
                    end
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                RSP_B: begin
                    if (rd_q) begin
                        b_rdata_q <= mem_dout;
                    end
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // RAM output is only valid during RSP, so read data bypasses to the ack cycle
    // and the captured copy is held afterwards.
    assign a_rdata = (state_q == RSP_A && rd_q) ? mem_dout : a_rdata_q;
    assign b_rdata = (state_q == RSP_B && rd_q) ? mem_dout : b_rdata_q;

    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign mem_addr = mem_addr_q;
    assign mem_we   = mem_we_q;
    assign mem_din  = mem_din_q;
    assign busy     = busy_q;

endmodule
